traffic_phase_scheduler: RTL and testbench
==========================================

# traffic_phase_scheduler

Intersection phase scheduler for the two-direction signalized crossing. It sequences the horizontal and vertical car heads through green, yellow, left-turn and yellow phases on a configurable tick base. Pedestrian crossings are served only on push-button demand, and an emergency-vehicle request preempts normal operation. Its four signal outputs use the existing 3-bit light encoding and drive the lamp drivers directly.

## Interface
- TICK_DIV, 1: clk cycles per tick, ≥1.
- T_GREEN, 20: car green duration, in ticks.
- T_YELLOW, 2: car yellow duration, in ticks.
- T_LEFT, 10: left-turn duration, in ticks.
- T_WALK, 14: walker steady green, in ticks.
- T_TWINKLE, 6: walker blinking green, in ticks. Constraint: T_WALK+T_TWINKLE ≤ T_GREEN; all durations ≥1.
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- i_h_walk_req  in  1  horizontal crosswalk button, level or pulse, sampled every clk.
- i_v_walk_req  in  1  vertical crosswalk button, same rules.
- i_emg_req  in  1  emergency preemption request, level-held while active.
- i_emg_dir  in  1  emergency direction to serve: 0 = horizontal, 1 = vertical.
- o_h_car_traffic, o_v_car_traffic, o_h_walker_traffic, o_v_walker_traffic  out  3 each  light codes: RED=000, GREEN=001, YELLOW=010, LEFT=011, GREEN_TWINKLE=100.
- o_phase  out  4  current state encoding (see Operation).
- o_h_walk_pending, o_v_walk_pending  out  1  walk request latched, not yet served.
- o_emg_active  out  1  high in states EMG_YELLOW, EMG_ALLRED and EMG_HOLD.

## Operation
- **States and o_phase codes:**
  - H_GREEN=0, H_YEL1=1, H_LEFT=2, H_YEL2=3
  - V_GREEN=4, V_YEL1=5, V_LEFT=6, V_YEL2=7
  - EMG_YELLOW=8, EMG_ALLRED=9, EMG_HOLD=10
- **Normal sequence:** 0→1→2→3→4→5→6→7→0. Durations are T_GREEN, T_YELLOW, T_LEFT, T_YELLOW.
- **Car heads:**
  - The active direction shows GREEN, YELLOW, LEFT or YELLOW according to the state.
  - The other direction shows RED.
- **Walk requests:**
  - A request sets the pending latch. The latch stays set until served.
  - On entry to H_GREEN, a set v pending latch is converted into a v grant and the latch is cleared. V_GREEN does the same for the h pending latch and h grant.
  - A request asserted in the entry cycle itself counts as pending, so it is granted.
- **Granted walker output, based on the phase timer t within the green phase:**
  - GREEN while t < T_WALK.
  - GREEN_TWINKLE while t < T_WALK+T_TWINKLE.
  - RED after that.
- **Ungranted walkers** are RED. All walkers are RED outside H_GREEN and V_GREEN. A grant expires when its green phase exits.
- **Emergency acceptance:**
  - i_emg_req high while in a GREEN or LEFT state: next state is EMG_YELLOW. i_emg_dir is latched in the same cycle.
  - Acceptance occurs in a YEL state: that yellow completes its remaining ticks, then goes to EMG_ALLRED. The direction is latched at that exit.
- **Emergency states:**
  - EMG_YELLOW: the previously active direction shows YELLOW for T_YELLOW ticks. Then EMG_ALLRED.
  - EMG_ALLRED: all heads RED for 1 tick. Then EMG_HOLD.
  - EMG_HOLD: the latched direction's car head shows GREEN. All other heads, car and walker, are RED.
- **Exit from EMG_HOLD:** the state holds while i_emg_req is high, for a minimum of 1 tick. On release, the next state is the latched direction's YEL2 (3 or 7), and normal sequencing resumes from there. i_emg_req is ignored while in the emergency states.
- **Pending latches** keep accumulating during an emergency. Grants are cleared when leaving a green phase.

## Timing
- **Prescaler:** counts 0..TICK_DIV-1. A tick occurs in the cycle where the count equals TICK_DIV-1. With TICK_DIV=1, every cycle is a tick.
- **Phase timer t:** increments on each tick. On the tick where t = duration-1, the state advances, and t and the prescaler return to 0.
- **Per-state duration:** each state lasts exactly duration×TICK_DIV clk cycles. The normal full cycle is 68 ticks with the default parameters.
- **Emergency transitions:** entry into EMG_YELLOW happens on the clk after sampling, not tick-aligned. At that point t and the prescaler are zeroed. Release from EMG_HOLD is also effective on the next clk.
- **Outputs** are a combinational decode of the registered state, t and grant registers. They change in the same cycle the state register updates and have no extra latency.
- **Reset**, applied in any state and at any time, takes effect on the next edge:
  - state = H_GREEN, t = 0, prescaler = 0.
  - Pending latches, grants and the emergency latch cleared.
  - Resulting outputs: h car GREEN, v car RED, both walkers RED, o_phase = 0, o_emg_active = 0, pending flags 0.
- **Inputs during reset:** requests asserted while reset is high are discarded.

## Test plan
- **Free run (TICK_DIV=1, no requests):** release reset at cycle 0.
  - h car: GREEN cycles 0–19, YELLOW 20–21, LEFT 22–31, YELLOW 32–33, RED 34–67.
  - v car: GREEN 34–53, YELLOW 54–55, LEFT 56–65, YELLOW 66–67.
  - Period is 68 cycles. Walkers stay RED throughout.
- **Vertical walk request:** pulse i_v_walk_req for 1 cycle during H_LEFT.
  - o_v_walk_pending goes high, then clears on the next H_GREEN entry.
  - v walker: GREEN for ticks 0–13, TWINKLE for ticks 14–19, then RED.
  - h walker stays RED.
- **Emergency from green:** assert i_emg_req with i_emg_dir=1 at H_GREEN t=5 and hold for 10 cycles.
  - Sequence: EMG_YELLOW (h YELLOW, 2 cycles) → EMG_ALLRED (1 cycle) → EMG_HOLD (v GREEN) until release.
  - After release: V_YEL2 for 2 cycles, then H_GREEN.
- **Emergency during yellow:** assert i_emg_req with i_emg_dir=0 at H_YEL1 t=0.
  - The yellow completes 2 ticks, then EMG_ALLRED, then EMG_HOLD with h GREEN.
  - A granted walker from the prior green has already expired: RED.
- **Slow tick:** TICK_DIV=4 → every state duration ×4 and a full period of 272 cycles. An emergency accepted mid-tick resets the prescaler.
- **Reset mid-operation:** set both walk requests pending, then assert reset in V_LEFT.
  - Next cycle: o_phase=0, both pending flags 0, walkers RED.
  - The run then proceeds exactly as in the free-run scenario.

Source files
------------

// File: rtl/traffic_phase_scheduler.sv
// Two-direction intersection phase scheduler with on-demand pedestrian
// crossings and emergency-vehicle preemption. Light outputs are a direct
// combinational decode of the registered state, phase timer and grants.
module traffic_phase_scheduler #(
  parameter int unsigned TICK_DIV  = 1,
  parameter int unsigned T_GREEN   = 20,
  parameter int unsigned T_YELLOW  = 2,
  parameter int unsigned T_LEFT    = 10,
  parameter int unsigned T_WALK    = 14,
  parameter int unsigned T_TWINKLE = 6
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_h_walk_req,
  input  logic       i_v_walk_req,
  input  logic       i_emg_req,
  input  logic       i_emg_dir,
  output logic [2:0] o_h_car_traffic,
  output logic [2:0] o_v_car_traffic,
  output logic [2:0] o_h_walker_traffic,
  output logic [2:0] o_v_walker_traffic,
  output logic [3:0] o_phase,
  output logic       o_h_walk_pending,
  output logic       o_v_walk_pending,
  output logic       o_emg_active
);

  localparam logic [2:0] LtRed     = 3'b000;
  localparam logic [2:0] LtGreen   = 3'b001;
  localparam logic [2:0] LtYellow  = 3'b010;
  localparam logic [2:0] LtLeft    = 3'b011;
  localparam logic [2:0] LtTwinkle = 3'b100;

  // Timer only has to reach the longest per-state duration.
  localparam int unsigned TMaxA = (T_GREEN > T_LEFT) ? T_GREEN : T_LEFT;
  localparam int unsigned TMax  = (TMaxA > T_YELLOW) ? TMaxA : T_YELLOW;
  localparam int unsigned TW    = $clog2(TMax + 1);
  localparam int unsigned PW    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  typedef enum logic [3:0] {
    StHGreen    = 4'd0,
    StHYel1     = 4'd1,
    StHLeft     = 4'd2,
    StHYel2     = 4'd3,
    StVGreen    = 4'd4,
    StVYel1     = 4'd5,
    StVLeft     = 4'd6,
    StVYel2     = 4'd7,
    StEmgYellow = 4'd8,
    StEmgAllred = 4'd9,
    StEmgHold   = 4'd10
  } state_e;

  state_e          state_q, state_d;
  logic [TW-1:0]   t_q, t_d;
  logic [PW-1:0]   presc_q, presc_d;
  logic            h_pend_q, h_pend_d, v_pend_q, v_pend_d;
  logic            h_grant_q, h_grant_d, v_grant_q, v_grant_d;
  logic            arm_q, arm_d;           // emergency accepted during a yellow
  logic            emg_dir_q, emg_dir_d;   // direction to serve in EMG_HOLD
  logic            prev_dir_q, prev_dir_d; // direction shown yellow in EMG_YELLOW
  logic [TW-1:0]   dur;
  logic            tick;
  logic            last;
  state_e          next_seq;

  assign tick     = (presc_q == PW'(TICK_DIV - 1));
  assign last     = tick && (t_q == dur - TW'(1));
  assign next_seq = state_e'({1'b0, state_q[2:0] + 3'd1});

  // Duration in ticks of the current state.
  always_comb begin
    dur = TW'(1);
    case (state_q)
      StHGreen, StVGreen:                      dur = TW'(T_GREEN);
      StHYel1, StHYel2, StVYel1, StVYel2:      dur = TW'(T_YELLOW);
      StHLeft, StVLeft:                        dur = TW'(T_LEFT);
      StEmgYellow:                             dur = TW'(T_YELLOW);
      default:                                 dur = TW'(1);
    endcase
  end

  // Next-state, timer, walk-latch and emergency-latch logic.
  always_comb begin
    state_d    = state_q;
    t_d        = t_q;
    presc_d    = presc_q;
    h_pend_d   = h_pend_q | i_h_walk_req;
    v_pend_d   = v_pend_q | i_v_walk_req;
    h_grant_d  = h_grant_q;
    v_grant_d  = v_grant_q;
    arm_d      = arm_q;
    emg_dir_d  = emg_dir_q;
    prev_dir_d = prev_dir_q;

    if (tick) begin
      presc_d = '0;
      t_d     = last ? '0 : t_q + TW'(1);
    end else begin
      presc_d = presc_q + PW'(1);
    end

    case (state_q)
      StHGreen, StHLeft, StVGreen, StVLeft: begin
        if (i_emg_req) begin
          // Immediate preemption, not tick-aligned.
          state_d    = StEmgYellow;
          emg_dir_d  = i_emg_dir;
          prev_dir_d = state_q[2];
          t_d        = '0;
          presc_d    = '0;
        end else if (last) begin
          state_d = next_seq;
        end
      end
      StHYel1, StHYel2, StVYel1, StVYel2: begin
        if (i_emg_req) arm_d = 1'b1;
        if (last) begin
          if (arm_q || i_emg_req) begin
            state_d   = StEmgAllred;
            emg_dir_d = i_emg_dir;
            arm_d     = 1'b0;
          end else begin
            state_d = next_seq;
          end
        end
      end
      StEmgYellow: begin
        if (last) state_d = StEmgAllred;
      end
      StEmgAllred: begin
        if (last) state_d = StEmgHold;
      end
      StEmgHold: begin
        // t saturates at 1 here and only marks that the minimum tick elapsed.
        if (!i_emg_req && (t_q != '0 || tick)) begin
          state_d = emg_dir_q ? StVYel2 : StHYel2;
          t_d     = '0;
          presc_d = '0;
        end else if (tick) begin
          t_d = TW'(1);
        end
      end
      default: begin
        state_d = StHGreen;
        t_d     = '0;
        presc_d = '0;
      end
    endcase

    // H_GREEN serves the vertical crosswalk, V_GREEN the horizontal one.
    if (state_d == StHGreen && state_q != StHGreen) begin
      v_grant_d = v_pend_q | i_v_walk_req;
      v_pend_d  = 1'b0;
    end else if (state_q == StHGreen && state_d != StHGreen) begin
      v_grant_d = 1'b0;
    end
    if (state_d == StVGreen && state_q != StVGreen) begin
      h_grant_d = h_pend_q | i_h_walk_req;
      h_pend_d  = 1'b0;
    end else if (state_q == StVGreen && state_d != StVGreen) begin
      h_grant_d = 1'b0;
    end
  end

  // State register with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StHGreen;
      t_q        <= '0;
      presc_q    <= '0;
      h_pend_q   <= 1'b0;
      v_pend_q   <= 1'b0;
      h_grant_q  <= 1'b0;
      v_grant_q  <= 1'b0;
      arm_q      <= 1'b0;
      emg_dir_q  <= 1'b0;
      prev_dir_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      t_q        <= t_d;
      presc_q    <= presc_d;
      h_pend_q   <= h_pend_d;
      v_pend_q   <= v_pend_d;
      h_grant_q  <= h_grant_d;
      v_grant_q  <= v_grant_d;
      arm_q      <= arm_d;
      emg_dir_q  <= emg_dir_d;
      prev_dir_q <= prev_dir_d;
    end
  end

  logic [2:0] walk_code;
  assign walk_code = (t_q < TW'(T_WALK))             ? LtGreen   :
                     (t_q < TW'(T_WALK + T_TWINKLE)) ? LtTwinkle : LtRed;

  // Light decode from registered state.
  always_comb begin
    o_h_car_traffic    = LtRed;
    o_v_car_traffic    = LtRed;
    o_h_walker_traffic = LtRed;
    o_v_walker_traffic = LtRed;
    case (state_q)
      StHGreen: begin
        o_h_car_traffic    = LtGreen;
        o_v_walker_traffic = v_grant_q ? walk_code : LtRed;
      end
      StHYel1, StHYel2: o_h_car_traffic = LtYellow;
      StHLeft:          o_h_car_traffic = LtLeft;
      StVGreen: begin
        o_v_car_traffic    = LtGreen;
        o_h_walker_traffic = h_grant_q ? walk_code : LtRed;
      end
      StVYel1, StVYel2: o_v_car_traffic = LtYellow;
      StVLeft:          o_v_car_traffic = LtLeft;
      StEmgYellow: begin
        if (prev_dir_q) o_v_car_traffic = LtYellow;
        else            o_h_car_traffic = LtYellow;
      end
      StEmgHold: begin
        if (emg_dir_q) o_v_car_traffic = LtGreen;
        else           o_h_car_traffic = LtGreen;
      end
      default: ;
    endcase
  end

  assign o_phase          = state_q;
  assign o_h_walk_pending = h_pend_q;
  assign o_v_walk_pending = v_pend_q;
  assign o_emg_active     = (state_q == StEmgYellow) || (state_q == StEmgAllred) ||
                            (state_q == StEmgHold);

endmodule

// File: tb/tb_traffic_phase_scheduler.sv
// Scoreboard bench: stimulus pushes the expected outputs for each cycle,
// a negedge monitor pops and compares against the selected DUT.
module tb_traffic_phase_scheduler;

  localparam logic [2:0] RED = 3'd0, GRN = 3'd1, YEL = 3'd2, LFT = 3'd3, TWK = 3'd4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic h_req = 1'b0, v_req = 1'b0, emg_req = 1'b0, emg_dir = 1'b0;

  logic [2:0] a_hc, a_vc, a_hw, a_vw, b_hc, b_vc, b_hw, b_vw;
  logic [3:0] a_ph, b_ph;
  logic       a_hp, a_vp, a_em, b_hp, b_vp, b_em;

  traffic_phase_scheduler dut1 (
    .clk(clk), .reset(reset), .i_h_walk_req(h_req), .i_v_walk_req(v_req),
    .i_emg_req(emg_req), .i_emg_dir(emg_dir),
    .o_h_car_traffic(a_hc), .o_v_car_traffic(a_vc),
    .o_h_walker_traffic(a_hw), .o_v_walker_traffic(a_vw),
    .o_phase(a_ph), .o_h_walk_pending(a_hp), .o_v_walk_pending(a_vp),
    .o_emg_active(a_em)
  );

  traffic_phase_scheduler #(.TICK_DIV(4)) dut4 (
    .clk(clk), .reset(reset), .i_h_walk_req(h_req), .i_v_walk_req(v_req),
    .i_emg_req(emg_req), .i_emg_dir(emg_dir),
    .o_h_car_traffic(b_hc), .o_v_car_traffic(b_vc),
    .o_h_walker_traffic(b_hw), .o_v_walker_traffic(b_vw),
    .o_phase(b_ph), .o_h_walk_pending(b_hp), .o_v_walk_pending(b_vp),
    .o_emg_active(b_em)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        sel;
    logic [3:0]  ph;
    logic [2:0]  hc, vc, hw, vw;
    logic        hp, vp, em;
    logic [15:0] cyc;
  } exp_t;

  exp_t  exp_q[$];
  string nm_q[$];
  int    total = 0;
  int    bad = 0;

  exp_t       e;
  string      n;
  logic [3:0] g_ph;
  logic [2:0] g_hc, g_vc, g_hw, g_vw;
  logic       g_hp, g_vp, g_em;

  // Monitor: one expected entry per cycle, compared mid-cycle.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n = nm_q.pop_front();
      if (e.sel) begin
        g_ph = b_ph; g_hc = b_hc; g_vc = b_vc; g_hw = b_hw; g_vw = b_vw;
        g_hp = b_hp; g_vp = b_vp; g_em = b_em;
      end else begin
        g_ph = a_ph; g_hc = a_hc; g_vc = a_vc; g_hw = a_hw; g_vw = a_vw;
        g_hp = a_hp; g_vp = a_vp; g_em = a_em;
      end
      total = total + 1;
      if ({g_ph, g_hc, g_vc, g_hw, g_vw, g_hp, g_vp, g_em} !==
          {e.ph, e.hc, e.vc, e.hw, e.vw, e.hp, e.vp, e.em}) begin
        bad = bad + 1;
        $display("FAIL %s cyc=%0d got ph=%0d hc=%0d vc=%0d hw=%0d vw=%0d hp=%0b vp=%0b em=%0b want ph=%0d hc=%0d vc=%0d hw=%0d vw=%0d hp=%0b vp=%0b em=%0b",
                 n, e.cyc, g_ph, g_hc, g_vc, g_hw, g_vw, g_hp, g_vp, g_em,
                 e.ph, e.hc, e.vc, e.hw, e.vw, e.hp, e.vp, e.em);
      end
    end
  end

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input string nm, input logic sel, input int c, input int ph,
                      input logic [2:0] hc, input logic [2:0] vc, input logic [2:0] hw,
                      input logic [2:0] vw, input logic hp, input logic vp, input logic em);
    exp_t x;
    x.sel = sel; x.ph = ph[3:0]; x.hc = hc; x.vc = vc; x.hw = hw; x.vw = vw;
    x.hp = hp; x.vp = vp; x.em = em; x.cyc = c[15:0];
    exp_q.push_back(x);
    nm_q.push_back(nm);
  endtask

  function automatic logic [2:0] head(input int k);
    case (k)
      0: return GRN;
      1: return YEL;
      2: return LFT;
      default: return YEL;
    endcase
  endfunction

  // Normal-cycle phase for a tick index (68-tick period, defaults).
  function automatic int sched(input int c);
    int m;
    m = c % 68;
    if (m < 20) return 0;
    if (m < 22) return 1;
    if (m < 32) return 2;
    if (m < 34) return 3;
    if (m < 54) return 4;
    if (m < 56) return 5;
    if (m < 66) return 6;
    return 7;
  endfunction

  function automatic logic [2:0] walk(input int t);
    if (t < 14) return GRN;
    if (t < 20) return TWK;
    return RED;
  endfunction

  task automatic push_norm(input string nm, input logic sel, input int c, input int ph,
                           input logic [2:0] hw, input logic [2:0] vw,
                           input logic hp, input logic vp);
    logic [2:0] hc, vc;
    hc = (ph < 4) ? head(ph) : RED;
    vc = (ph >= 4) ? head(ph - 4) : RED;
    push(nm, sel, c, ph, hc, vc, hw, vw, hp, vp, 1'b0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    nxt();
    nxt();
    reset = 1'b0;
  endtask

  initial begin
    logic [2:0] vw;

    // Free run, no requests.
    do_reset();
    for (int c = 0; c < 70; c++) begin
      push_norm("free_run", 1'b0, c, sched(c), RED, RED, 1'b0, 1'b0);
      nxt();
    end

    // Vertical walk request pulsed during H_LEFT.
    do_reset();
    for (int c = 0; c < 96; c++) begin
      vw = (c >= 68 && c < 88) ? walk(c - 68) : RED;
      push_norm("v_walk", 1'b0, c, sched(c), RED, vw, 1'b0, (c >= 26 && c < 68));
      v_req = (c == 25);
      nxt();
    end
    v_req = 1'b0;

    // Emergency from H_GREEN t=5, vertical, held 10 cycles.
    do_reset();
    emg_dir = 1'b1;
    for (int c = 0; c <= 40; c++) begin
      if (c <= 5)       push_norm("emg_green", 1'b0, c, 0, RED, RED, 1'b0, 1'b0);
      else if (c <= 7)  push("emg_green", 1'b0, c, 8, YEL, RED, RED, RED, 1'b0, 1'b0, 1'b1);
      else if (c == 8)  push("emg_green", 1'b0, c, 9, RED, RED, RED, RED, 1'b0, 1'b0, 1'b1);
      else if (c <= 15) push("emg_green", 1'b0, c, 10, RED, GRN, RED, RED, 1'b0, 1'b0, 1'b1);
      else if (c <= 17) push_norm("emg_green", 1'b0, c, 7, RED, RED, 1'b0, 1'b0);
      else              push_norm("emg_green", 1'b0, c, sched(c - 18), RED, RED, 1'b0, 1'b0);
      emg_req = (c >= 5 && c <= 14);
      nxt();
    end
    emg_req = 1'b0;

    // Emergency during H_YEL1 after a granted v walk; h request held in reset.
    h_req = 1'b1;
    do_reset();
    h_req = 1'b0;
    emg_dir = 1'b0;
    for (int c = 0; c <= 102; c++) begin
      vw = (c >= 68 && c < 88) ? walk(c - 68) : RED;
      if (c <= 89)      push_norm("emg_yel", 1'b0, c, sched(c), RED, vw, 1'b0,
                                  (c >= 1 && c < 68));
      else if (c == 90) push("emg_yel", 1'b0, c, 9, RED, RED, RED, RED, 1'b0, 1'b0, 1'b1);
      else if (c <= 96) push("emg_yel", 1'b0, c, 10, GRN, RED, RED, RED, 1'b0, 1'b0, 1'b1);
      else if (c <= 98) push_norm("emg_yel", 1'b0, c, 3, RED, RED, 1'b0, 1'b0);
      else              push_norm("emg_yel", 1'b0, c, 4, RED, RED, 1'b0, 1'b0);
      v_req   = (c == 0);
      emg_req = (c >= 88 && c <= 95);
      nxt();
    end
    v_req = 1'b0;
    emg_req = 1'b0;

    // Slow tick instance: full period then a mid-tick emergency.
    do_reset();
    emg_dir = 1'b1;
    for (int c = 0; c <= 305; c++) begin
      if (c < 275)       push_norm("slow", 1'b1, c, sched(c / 4), RED, RED, 1'b0, 1'b0);
      else if (c <= 282) push("slow", 1'b1, c, 8, YEL, RED, RED, RED, 1'b0, 1'b0, 1'b1);
      else if (c <= 286) push("slow", 1'b1, c, 9, RED, RED, RED, RED, 1'b0, 1'b0, 1'b1);
      else if (c <= 291) push("slow", 1'b1, c, 10, RED, GRN, RED, RED, 1'b0, 1'b0, 1'b1);
      else if (c <= 299) push_norm("slow", 1'b1, c, 7, RED, RED, 1'b0, 1'b0);
      else               push_norm("slow", 1'b1, c, 0, RED, RED, 1'b0, 1'b0);
      emg_req = (c >= 274 && c <= 290);
      nxt();
    end
    emg_req = 1'b0;

    // Both walks pending, reset in V_LEFT with requests discarded.
    do_reset();
    for (int c = 0; c <= 58; c++) begin
      push_norm("pre_reset", 1'b0, c, sched(c), RED, RED, (c >= 41), (c >= 41));
      h_req = (c == 40);
      v_req = (c == 40);
      if (c == 58) begin
        reset = 1'b1;
        h_req = 1'b1;
        v_req = 1'b1;
      end
      nxt();
    end
    reset = 1'b0;
    h_req = 1'b0;
    v_req = 1'b0;
    for (int c = 0; c < 70; c++) begin
      push_norm("post_reset", 1'b0, c, sched(c), RED, RED, 1'b0, 1'b0);
      nxt();
    end

    nxt();
    nxt();
    if (exp_q.size() != 0) begin
      total = total + 1;
      bad = bad + 1;
      $display("FAIL drain got=%0d entries left required=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
